// File: rtl/adc_capture_seq.sv
// ADC capture sequencer: optional SYSREF alignment, programmable holdoff, then writes
// a fixed number of AXI4-Stream beats into a capture buffer and hands off via trig/ack.
module adc_capture_seq #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 10,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    arm_i,
    input  logic                    abort_i,
    input  logic                    sync_mode_i,
    input  logic                    sysref_i,
    input  logic [DELAY_WIDTH-1:0]  delay_i,
    input  logic [ADDR_WIDTH-1:0]   len_i,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    buf_we_o,
    output logic [ADDR_WIDTH-1:0]   buf_addr_o,
    output logic [DATA_WIDTH-1:0]   buf_data_o,
    output logic                    trig_o,
    input  logic                    trig_ack_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADDR_WIDTH:0]     count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_DELAY,
        S_CAPTURE,
        S_TRIG,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [DELAY_WIDTH-1:0] dly_cnt;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [ADDR_WIDTH:0]    beat_cnt;
    logic [ADDR_WIDTH:0]    beat_tgt;
    logic [ADDR_WIDTH:0]    beat_nx;
    logic                   sysref_prev;
    logic                   sysref_rise;
    logic                   wr_en;
    logic                   last_beat;

    assign sysref_rise = sysref_i & ~sysref_prev;
    assign wr_en       = (state == S_CAPTURE) & s_axis_tvalid & ~abort_i;
    assign beat_nx     = beat_cnt + 1'b1;
    assign last_beat   = wr_en & (beat_nx == beat_tgt);

    always_comb begin
        state_nx = state;
        if (abort_i && (state != S_IDLE)) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (arm_i) state_nx = sync_mode_i ? S_WAIT_SYNC : S_DELAY;
                S_WAIT_SYNC: if (sysref_rise) state_nx = S_DELAY;
                // a delay of 0 or 1 both leave after a single cycle
                S_DELAY:     if (dly_cnt <= DELAY_WIDTH'(1)) state_nx = S_CAPTURE;
                S_CAPTURE:   if (last_beat) state_nx = S_TRIG;
                S_TRIG:      if (trig_ack_i) state_nx = S_DONE;
                S_DONE:      state_nx = S_IDLE;
                default:     state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            sysref_prev <= 1'b0;
            dly_cnt     <= '0;
            wr_addr     <= '0;
            beat_cnt    <= '0;
            beat_tgt    <= '0;
            busy_o      <= 1'b0;
            trig_o      <= 1'b0;
            done_o      <= 1'b0;
            buf_we_o    <= 1'b0;
            buf_addr_o  <= '0;
            buf_data_o  <= '0;
            count_o     <= '0;
        end else begin
            state       <= state_nx;
            sysref_prev <= sysref_i;
            // status outputs registered from the next state, so no decode glitches
            busy_o      <= (state_nx != S_IDLE);
            trig_o      <= (state_nx == S_TRIG);
            done_o      <= (state_nx == S_DONE);
            buf_we_o    <= wr_en;
            if (wr_en) begin
                buf_addr_o <= wr_addr;
                buf_data_o <= s_axis_tdata;
                wr_addr    <= wr_addr + 1'b1;
                beat_cnt   <= beat_nx;
            end
            if (last_beat) begin
                count_o <= beat_nx;
            end
            if ((state == S_IDLE) && arm_i) begin
                dly_cnt  <= delay_i;
                beat_tgt <= {(len_i == '0), len_i};
                wr_addr  <= '0;
                beat_cnt <= '0;
            end
            if (state == S_DELAY) begin
                dly_cnt <= dly_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_seq.sv
// Scoreboard bench for adc_capture_seq: stimulus queues expected writes, a monitor pops them.
module tb_adc_capture_seq;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          sync_mode_i = 1'b0;
    logic          sysref_i = 1'b0;
    logic [LW-1:0] delay_i = '0;
    logic [AW-1:0] len_i = '0;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          buf_we_o;
    logic [AW-1:0] buf_addr_o;
    logic [DW-1:0] buf_data_o;
    logic          trig_o;
    logic          trig_ack_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   count_o;

    typedef struct {
        int addr;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tv_mode = 1;

    adc_capture_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DELAY_WIDTH(LW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .arm_i         (arm_i),
        .abort_i       (abort_i),
        .sync_mode_i   (sync_mode_i),
        .sysref_i      (sysref_i),
        .delay_i       (delay_i),
        .len_i         (len_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .buf_we_o      (buf_we_o),
        .buf_addr_o    (buf_addr_o),
        .buf_data_o    (buf_data_o),
        .trig_o        (trig_o),
        .trig_ack_i    (trig_ack_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .count_o       (count_o)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Beat driver: data encodes the edge that samples it; tv_mode 2 offers beats on even edges only
    initial begin
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            s_axis_tdata = 32'h5A00_0000 + DW'(cyc + 1);
            case (tv_mode)
                0:       s_axis_tvalid = 1'b0;
                1:       s_axis_tvalid = 1'b1;
                default: s_axis_tvalid = (((cyc + 1) % 2) == 0);
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && buf_we_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr %0d data %h at edge %0d", buf_addr_o, buf_data_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ((buf_addr_o !== AW'(e.addr)) || (buf_data_o !== (32'h5A00_0000 + DW'(e.edge_no)))
                        || (cyc != e.edge_no)) begin
                        errors++;
                        $display("FAIL write got addr %0d data %h edge %0d exp addr %0d data %h edge %0d",
                                 buf_addr_o, buf_data_o, cyc, e.addr, 32'h5A00_0000 + e.edge_no, e.edge_no);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int a, input int e);
        exp_t x;
        x.addr    = a;
        x.edge_no = e;
        exp_q.push_back(x);
    endtask

    task automatic start(input logic sm, input int d, input int l, output int s);
        sync_mode_i = sm;
        delay_i     = LW'(d);
        len_i       = AW'(l);
        arm_i       = 1'b1;
        tick(1);
        arm_i       = 1'b0;
        s           = cyc;
    endtask

    task automatic do_ack();
        trig_ack_i = 1'b1;
        tick(1);
        trig_ack_i = 1'b0;
        chk("trig_drop", trig_o, 0);
        chk("done_pulse", done_o, 1);
        tick(1);
        chk("done_once", done_o, 0);
        chk("back_idle", busy_o, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int s;
        int r;
        int e;
        int k;
        tick(2);
        chk("rst_busy", busy_o, 0);
        chk("rst_trig", trig_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_we", buf_we_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_addr", buf_addr_o, 0);
        chk("rst_data", buf_data_o, 0);

        // free-running, delay 3, len 4; arm lands on the first edge out of reset
        aresetn = 1'b1;
        start(1'b0, 3, 4, s);
        for (int i = 0; i < 4; i++) push(i, s + 4 + i);
        tick(6);
        chk("t1_trig_early", trig_o, 0);
        tick(1);
        chk("t1_trig", trig_o, 1);
        chk("t1_count", count_o, 4);
        chk("t1_busy", busy_o, 1);
        do_ack();

        // sync mode with SYSREF already high: only a fresh rising edge starts the holdoff
        sysref_i = 1'b1;
        start(1'b1, 2, 2, s);
        chk("t2_wait_busy", busy_o, 1);
        tick(3);
        sysref_i = 1'b0;
        tick(2);
        sysref_i = 1'b1;
        r = cyc + 1;
        push(0, r + 3);
        push(1, r + 4);
        tick(4);
        sysref_i = 1'b0;
        chk("t2_trig_early", trig_o, 0);
        tick(1);
        chk("t2_trig", trig_o, 1);
        chk("t2_count", count_o, 2);
        do_ack();

        // full depth (len 0) with gappy tvalid
        tv_mode = 2;
        start(1'b0, 0, 0, s);
        e = s + 2;
        k = 0;
        while (k < 16) begin
            if ((e % 2) == 0) begin
                push(k, e);
                k++;
            end
            e++;
        end
        tick(e - 1 - cyc);
        chk("t3_trig", trig_o, 1);
        chk("t3_count", count_o, 16);
        chk("t3_addr_hold", buf_addr_o, 15);
        do_ack();
        tv_mode = 1;

        // abort after two writes, then a fresh capture
        start(1'b0, 1, 8, s);
        push(0, s + 2);
        push(1, s + 3);
        tick(3);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        chk("t4_abort_we", buf_we_o, 0);
        chk("t4_abort_busy", busy_o, 0);
        chk("t4_abort_trig", trig_o, 0);
        chk("t4_abort_count", count_o, 16);
        tick(3);
        chk("t4_no_done", done_o, 0);
        chk("t4_sb_empty", exp_q.size(), 0);
        start(1'b0, 2, 3, s);
        for (int i = 0; i < 3; i++) push(i, s + 3 + i);
        tick(5);
        chk("t4_trig", trig_o, 1);
        chk("t4_count", count_o, 3);
        do_ack();

        // abort coinciding with the final beat suppresses that write
        start(1'b0, 0, 2, s);
        push(0, s + 2);
        tick(2);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        chk("t5_last_we", buf_we_o, 0);
        chk("t5_trig", trig_o, 0);
        chk("t5_count", count_o, 3);
        chk("t5_busy", busy_o, 0);
        chk("t5_sb_empty", exp_q.size(), 0);

        // arm together with abort in IDLE starts; long ack holdoff ignores arm
        abort_i = 1'b1;
        start(1'b0, 1, 1, s);
        abort_i = 1'b0;
        chk("t6_started", busy_o, 1);
        push(0, s + 2);
        tick(2);
        chk("t6_trig", trig_o, 1);
        chk("t6_count", count_o, 1);
        for (int i = 0; i < 50; i++) begin
            arm_i = ((i % 10) == 3);
            tick(1);
            if ((i % 10) == 9) chk("t6_trig_hold", trig_o, 1);
        end
        arm_i = 1'b0;
        do_ack();

        // asynchronous reset between clock edges during holdoff
        start(1'b0, 20, 4, s);
        tick(3);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t7_busy", busy_o, 0);
        chk("t7_trig", trig_o, 0);
        chk("t7_done", done_o, 0);
        chk("t7_we", buf_we_o, 0);
        chk("t7_count", count_o, 0);
        chk("t7_addr", buf_addr_o, 0);
        chk("t7_data", buf_data_o, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tick(3);
        chk("t7_idle", busy_o, 0);
        chk("t7_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_seq.md
ADC_CAPTURE_SEQ -- requirements
Module: adc_capture_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 128, AXI4-Stream ADC sample bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, capture buffer address width; buffer depth is 2^ADDR_WIDTH beats.
REQ-003 Parameter DELAY_WIDTH, default 16, width of the post-sync holdoff counter.
REQ-004 aclk  in  1  sole clock, the ADC AXI4-Stream clock; all logic is on its rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 arm_i  in  1  single-cycle capture request.
REQ-007 abort_i  in  1  single-cycle cancel of any capture in progress.
REQ-008 sync_mode_i  in  1  1 = wait for a SYSREF rising edge before the holdoff; 0 = start the holdoff immediately.
REQ-009 sysref_i  in  1  SYSREF, already registered in the aclk domain.
REQ-010 delay_i  in  DELAY_WIDTH  holdoff length in aclk cycles.
REQ-011 len_i  in  ADDR_WIDTH  number of beats to capture; 0 means 2^ADDR_WIDTH.
REQ-012 s_axis_tdata  in  DATA_WIDTH  ADC sample beat.
REQ-013 s_axis_tvalid  in  1  beat qualifier; the block never backpressures, so it has no tready.
REQ-014 buf_we_o  out  1  buffer write enable.
REQ-015 buf_addr_o  out  ADDR_WIDTH  buffer write address.
REQ-016 buf_data_o  out  DATA_WIDTH  buffer write data.
REQ-017 trig_o  out  1  capture-complete request to the readout consumer; held until acknowledged.
REQ-018 trig_ack_i  in  1  consumer acknowledge.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 done_o  out  1  single-cycle completion pulse.
REQ-021 count_o  out  ADDR_WIDTH+1  number of beats written by the last completed capture.

Function
REQ-022 The FSM shall have states IDLE, WAIT_SYNC, DELAY, CAPTURE, TRIG and DONE, encoded as registers with no combinational outputs on state decode paths.
REQ-023 In IDLE, arm_i=1 shall latch sync_mode_i, delay_i and len_i, clear the write address, and move to WAIT_SYNC if the latched sync_mode is 1, otherwise to DELAY; arm_i in any other state shall be ignored.
REQ-024 WAIT_SYNC shall move to DELAY on the first cycle with sysref_i=1 and the internally registered previous sysref_i=0; a level held high on entry shall not count as an edge.
REQ-025 The previous-sysref register shall update every cycle in every state.
REQ-026 DELAY shall remain for exactly the latched delay cycles, then enter CAPTURE; a delay of 0 shall enter CAPTURE on the next cycle.
REQ-027 In CAPTURE, each cycle with s_axis_tvalid=1 shall produce one write: buf_we_o=1, buf_data_o=tdata and buf_addr_o=current address, all registered, so the write appears exactly 1 cycle after the input beat; the address then increments.
REQ-028 Cycles in CAPTURE with s_axis_tvalid=0 shall produce no write and no address change.
REQ-029 The beat that completes the latched length shall be written, and the FSM shall enter TRIG on the following cycle; with len 0 the address wraps to 0 after 2^ADDR_WIDTH beats and there is no overwrite.
REQ-030 On entering TRIG, count_o shall update to the number of beats written, width ADDR_WIDTH+1 so that the full-depth count 2^ADDR_WIDTH is representable.
REQ-031 In TRIG, trig_o shall be 1; the first cycle with trig_ack_i=1 shall drop trig_o on the next cycle and enter DONE.
REQ-032 trig_ack_i outside TRIG shall be ignored.
REQ-033 DONE shall assert done_o for exactly one cycle and then return to IDLE.
REQ-034 An abort_i=1 in any non-IDLE state shall force IDLE on the next cycle, deassert buf_we_o and trig_o, leave count_o unchanged and produce no done_o.
REQ-035 abort_i in IDLE shall have no effect; abort_i and arm_i asserted together in IDLE shall start the capture.
REQ-036 abort_i asserted in the same cycle as the final CAPTURE beat shall still suppress the write of that beat.

Reset
REQ-037 With aresetn=0, asynchronously: state=IDLE, address=0, buf_we_o=0, trig_o=0, busy_o=0, done_o=0, count_o=0, previous-sysref=0, buf_addr_o=0, buf_data_o=0.
REQ-038 The block shall leave reset on the first aclk edge after aresetn rises and shall accept arm_i on that edge.

Verification
REQ-039 sync_mode=0, delay=3, len=4, tvalid always 1: arm at cycle 0 -> 4 writes, addresses 0..3, on consecutive cycles; trig_o high; count_o=4; ack -> done_o pulse then IDLE.
REQ-040 sync_mode=1, sysref already high at arm: no capture until sysref falls and rises again; the first write occurs delay+2 cycles after the rising edge.
REQ-041 len=0, ADDR_WIDTH=4, tvalid toggling 1/0 -> exactly 16 writes, address wraps 15 to 0 only after trig_o, count_o=16.
REQ-042 Abort mid-CAPTURE after 2 writes -> buf_we_o is 0 next cycle, no trig_o, no done_o, count_o keeps its previous value, a fresh arm works.
REQ-043 Hold trig_ack_i low for 50 cycles in TRIG -> trig_o stays high and arm_i pulses are ignored; ack -> done_o fires once.
REQ-044 Assert aresetn=0 mid-DELAY between clock edges -> all outputs reach their reset values immediately, without waiting for a clock edge.
